// File: rtl/mcu_block_sched.sv
// mcu_block_sched: reorders BUF_AMOUNT line streams into BLOCK_W x BUF_AMOUNT block-ordered pixels
// Optional feature macro: MCU_SCHED_ERR_EN adds err_o, a sticky line-length (tlast) error flag.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   video_i_*             one AXI4-Stream slave per line buffer (index = line within band)
//   video_o_*             block-ordered AXI4-Stream master, tlast on last pixel of each block
//   err_o                 sticky error flag (MCU_SCHED_ERR_EN only)
module mcu_block_sched #(
   parameter int BUF_AMOUNT  = 8,
   parameter int BLOCK_W     = 8,
   parameter int PX_WIDTH    = 8,
   parameter int FRAME_RES_X = 1280,
   parameter int USER_W      = 1,
   parameter int ID_W        = 1,
   parameter int DEST_W      = 1,
   localparam int TW         = ((PX_WIDTH + 7) / 8) * 8,
   localparam int KW         = TW / 8
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic [BUF_AMOUNT-1:0][TW-1:0]       video_i_tdata,
   input  logic [BUF_AMOUNT-1:0]               video_i_tvalid,
   output logic [BUF_AMOUNT-1:0]               video_i_tready,
   input  logic [BUF_AMOUNT-1:0]               video_i_tlast,
   input  logic [BUF_AMOUNT-1:0][USER_W-1:0]   video_i_tuser,
   input  logic [BUF_AMOUNT-1:0][KW-1:0]       video_i_tstrb,
   input  logic [BUF_AMOUNT-1:0][KW-1:0]       video_i_tkeep,
   input  logic [BUF_AMOUNT-1:0][ID_W-1:0]     video_i_tid,
   input  logic [BUF_AMOUNT-1:0][DEST_W-1:0]   video_i_tdest,
   output logic [TW-1:0]                       video_o_tdata,
   output logic                                video_o_tvalid,
   input  logic                                video_o_tready,
   output logic                                video_o_tlast,
   output logic [USER_W-1:0]                   video_o_tuser,
   output logic [KW-1:0]                       video_o_tstrb,
   output logic [KW-1:0]                       video_o_tkeep,
   output logic [ID_W-1:0]                     video_o_tid,
   output logic [DEST_W-1:0]                   video_o_tdest
`ifdef MCU_SCHED_ERR_EN
   ,
   output logic                                err_o
`endif
);
   localparam int NBLK = FRAME_RES_X / BLOCK_W;
   localparam int CW = (BLOCK_W > 1) ? $clog2(BLOCK_W) : 1;
   localparam int RW = (BUF_AMOUNT > 1) ? $clog2(BUF_AMOUNT) : 1;
   localparam int BW = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam logic [CW-1:0] COL_MAX = CW'(BLOCK_W - 1);
   localparam logic [RW-1:0] ROW_MAX = RW'(BUF_AMOUNT - 1);
   localparam logic [BW-1:0] BLK_MAX = BW'(NBLK - 1);
   typedef enum logic {WAIT_BAND, RUN} state_t;
   state_t r_state, w_state_nxt;
   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;
   logic [BW-1:0] r_blk;
   logic w_col_max, w_row_max, w_blk_max, w_rdy, w_xfer, w_band_end;
   assign w_col_max = r_col == COL_MAX;
   assign w_row_max = r_row == ROW_MAX;
   assign w_blk_max = r_blk == BLK_MAX;
   // The output stage can take a pixel when empty or being drained this cycle.
   assign w_rdy = (r_state == RUN) && (!video_o_tvalid || video_o_tready);
   assign w_xfer = w_rdy && video_i_tvalid[r_row];
   assign w_band_end = w_xfer && w_col_max && w_row_max && w_blk_max;
   assign video_i_tready = w_rdy ? (BUF_AMOUNT'(1) << r_row) : '0;
   // A band starts only once every line buffer has data, so the block walk never stalls on an empty line.
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == WAIT_BAND) ? (&video_i_tvalid ? RUN : WAIT_BAND)
                                           : (w_band_end ? WAIT_BAND : RUN);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= WAIT_BAND;
      else       r_state <= w_state_nxt;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_col <= '0;
         r_row <= '0;
         r_blk <= '0;
      end else if (w_xfer) begin
         r_col <= w_col_max ? '0 : r_col + 1'b1;
         if (w_col_max) begin
            r_row <= w_row_max ? '0 : r_row + 1'b1;
            if (w_row_max) r_blk <= w_blk_max ? '0 : r_blk + 1'b1;
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         video_o_tvalid <= 1'b0;
         video_o_tlast  <= 1'b0;
         video_o_tuser  <= '0;
         video_o_tdata  <= '0;
         video_o_tstrb  <= '0;
         video_o_tkeep  <= '0;
         video_o_tid    <= '0;
         video_o_tdest  <= '0;
      end else if (w_xfer) begin
         video_o_tvalid <= 1'b1;
         video_o_tlast  <= w_col_max && w_row_max;
         video_o_tuser  <= video_i_tuser[r_row];
         video_o_tdata  <= video_i_tdata[r_row];
         video_o_tstrb  <= video_i_tstrb[r_row];
         video_o_tkeep  <= video_i_tkeep[r_row];
         video_o_tid    <= video_i_tid[r_row];
         video_o_tdest  <= video_i_tdest[r_row];
      end else if (video_o_tready) begin
         video_o_tvalid <= 1'b0;
      end
   end
`ifdef MCU_SCHED_ERR_EN
   // A line must end exactly on the last column of the last block.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_o <= 1'b0;
      else if (w_xfer && (video_i_tlast[r_row] != (w_blk_max && w_col_max))) err_o <= 1'b1;
   end
`else
   logic w_unused;
   assign w_unused = ^video_i_tlast;
`endif
endmodule

// File: doc/mcu_block_sched.md
MCU_BLOCK_SCHED -- requirements
Module: mcu_block_sched

Interface
REQ-001 Parameter BUF_AMOUNT, default 8: number of line-buffer streams; also block height.
REQ-002 Parameter BLOCK_W, default 8: block width in pixels.
REQ-003 Parameter PX_WIDTH, default 8: pixel width; TDATA_WIDTH = PX_WIDTH rounded up to a multiple of 8.
REQ-004 Parameter FRAME_RES_X, default 1280: line length in pixels; SHALL be a multiple of BLOCK_W.
REQ-005 clk_i  input  1  single clock for all logic.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 video_i[BUF_AMOUNT-1:0]  axi4_stream_if.slave  TDATA_WIDTH  one line stream per buffer; index = line within band.
REQ-008 video_o  axi4_stream_if.master  TDATA_WIDTH  block-ordered pixel stream; tlast marks last pixel of each block.
REQ-009 err_o  output  1  sticky line-length error flag; present only with MCU_SCHED_ERR_EN.

Function
REQ-010 Counters: col_cnt 0..BLOCK_W-1, row_cnt 0..BUF_AMOUNT-1, blk_cnt 0..FRAME_RES_X/BLOCK_W-1.
REQ-011 States: WAIT_BAND and RUN.
REQ-012 WAIT_BAND: all video_i tready low; go to RUN on the cycle all BUF_AMOUNT video_i tvalid are high; counters all zero.
REQ-013 RUN: only video_i[row_cnt] is selected; all other video_i tready SHALL be low.
REQ-014 Selected tready = RUN && (!video_o.tvalid || video_o.tready).
REQ-015 Input transfer = selected tvalid && tready; each transfer advances col_cnt.
REQ-016 col_cnt wraps at BLOCK_W-1 and increments row_cnt; row_cnt wraps at BUF_AMOUNT-1 and increments blk_cnt.
REQ-017 Transfer with col_cnt, row_cnt, blk_cnt all at maximum: counters clear, state returns to WAIT_BAND.
REQ-018 Output is one register stage: tdata, tuser, tstrb, tkeep, tid, tdest copied from selected input on transfer; latency 1 cycle.
REQ-019 video_o.tlast set when the loaded pixel has col_cnt==BLOCK_W-1 and row_cnt==BUF_AMOUNT-1.
REQ-020 video_o.tvalid set on input transfer; cleared when video_o.tready is high and there is no new transfer that cycle.
REQ-021 Simultaneous output accept and input transfer keeps tvalid high with new data; throughput 1 pixel/cycle.
REQ-022 Output fields SHALL hold stable while tvalid && !tready.
REQ-023 Input tuser passes through unchanged with its pixel; frame start appears on pixel 0 of block 0.
REQ-024 Input tlast is consumed and not forwarded.

Reset
REQ-025 rst_i high: state WAIT_BAND; all counters 0; video_o.tvalid, tlast, tuser 0; all video_i tready 0; err_o 0.
REQ-026 Reset mid-block discards partial block; the first block after reset release starts at row 0, col 0.

Configuration
REQ-027 Macro MCU_SCHED_ERR_EN defined: err_o exists.
REQ-028 With MCU_SCHED_ERR_EN, err_o is set on any selected-input transfer whose tlast differs from (blk_cnt==max && col_cnt==BLOCK_W-1).
REQ-029 With MCU_SCHED_ERR_EN, err_o stays high until rst_i; sequencing is unaffected.
REQ-030 MCU_SCHED_ERR_EN undefined: no err_o port, no check logic; tlast ignored.

Verification (BUF_AMOUNT=8, BLOCK_W=8, FRAME_RES_X=16, pixel value = line*16+x)
REQ-031 Full band, tready always 1 -> output 0..7,16..23,...,112..119 (tlast on 119), then 8..15,...,120..127 (tlast on 127); 128 beats in 128 cycles after RUN entry.
REQ-032 Lines 0-6 valid, line 7 empty -> all video_i tready stay 0 and no output until line 7 tvalid rises.
REQ-033 Random video_o.tready backpressure 50% -> identical sequence; no loss or duplication; output stable while stalled.
REQ-034 tuser=1 on line 0 pixel 0 -> video_o.tuser=1 only on first output beat; second band tuser=0.
REQ-035 rst_i pulsed after 20 beats, then full band resent -> output restarts at pixel 0; no stale beat.
REQ-036 MCU_SCHED_ERR_EN, line 3 tlast at x=7 -> err_o rises the cycle after that transfer and stays high; without macro, same stimulus gives normal output.
